// File: rtl/num_formatter.sv
// Formats a signed 16-bit value as an 8-slot right-aligned glyph frame (digits, '.', '-', blank)
// and streams it one slot per valid/ready handshake, leftmost slot first.
module num_formatter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] value,
    input  logic [2:0]  dp_pos,
    input  logic        char_ready,
    output logic        char_valid,
    output logic [3:0]  char_code,
    output logic [2:0]  char_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StConv, StBuild, StSend} state_e;

    localparam logic [3:0] GlyphDot   = 4'hC;
    localparam logic [3:0] GlyphBlank = 4'hE;
    localparam logic [3:0] GlyphMinus = 4'hF;

    state_e          state_q, state_d;
    logic            neg_q, neg_d;
    logic [2:0]      dp_q, dp_d;
    logic [15:0]     bin_q, bin_d;
    logic [19:0]     bcd_q, bcd_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0][3:0] frame_q, frame_d;
    logic            valid_q, valid_d;
    logic [3:0]      code_q, code_d;
    logic [2:0]      idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Magnitude fits in 16 unsigned bits: -32768 maps to 16'h8000.
    logic [15:0] mag;
    logic [2:0]  dp_sat;

    assign mag    = value[15] ? (~value + 16'd1) : value;
    assign dp_sat = (dp_pos > 3'd4) ? 3'd4 : dp_pos;

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
    logic [19:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int j = 0; j < 5; j++) begin
            if (bcd_q[4*j +: 4] >= 4'd5) begin
                bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
            end
        end
    end

    // Frame assembly from the converted digits; slot 7 is the rightmost glyph.
    logic [7:0][3:0] frame_build;
    logic [2:0]      hi;
    logic [2:0]      n_shown;
    logic [2:0]      pos;
    logic            has_dot;

    always_comb begin
        hi = 3'd0;
        for (int j = 0; j < 5; j++) begin
            if (bcd_q[4*j +: 4] != 4'd0) begin
                hi = 3'(j);
            end
        end
        n_shown     = (hi > dp_q) ? hi + 3'd1 : dp_q + 3'd1;
        has_dot     = (dp_q != 3'd0);
        frame_build = {8{GlyphBlank}};
        pos         = 3'd0;
        for (int j = 0; j < 5; j++) begin
            pos = 3'(j) + ((has_dot && (3'(j) >= dp_q)) ? 3'd1 : 3'd0);
            if (3'(j) < n_shown) begin
                frame_build[3'd7 - pos] = bcd_q[4*j +: 4];
            end
        end
        if (has_dot) begin
            frame_build[3'd7 - dp_q] = GlyphDot;
        end
        if (neg_q) begin
            frame_build[3'd7 - n_shown - {2'b00, has_dot}] = GlyphMinus;
        end
    end

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        dp_d    = dp_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        valid_d = valid_q;
        code_d  = code_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    neg_d   = value[15];
                    dp_d    = dp_sat;
                    bin_d   = mag;
                    bcd_d   = 20'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StConv;
                end
            end
            StConv: begin
                bcd_d = (bcd_adj << 1) | {19'd0, bin_q[15]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StBuild;
                end
            end
            StBuild: begin
                frame_d = frame_build;
                valid_d = 1'b1;
                idx_d   = 3'd0;
                code_d  = frame_build[0];
                state_d = StSend;
            end
            StSend: begin
                if (char_ready) begin
                    if (idx_q == 3'd7) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        code_d = frame_q[idx_q + 3'd1];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            neg_q   <= 1'b0;
            dp_q    <= 3'd0;
            bin_q   <= 16'd0;
            bcd_q   <= 20'd0;
            cnt_q   <= 4'd0;
            frame_q <= {8{GlyphBlank}};
            valid_q <= 1'b0;
            code_q  <= GlyphBlank;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            dp_q    <= dp_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign char_valid = valid_q;
    assign char_code  = code_q;
    assign char_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_num_formatter.sv
// Self-checking bench for num_formatter: decimal-arithmetic frame model, per-cycle stream monitor,
// directed frames with full-rate, random-backpressure, start-spam and mid-frame reset cases.
module tb_num_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] value = 16'd0;
    logic [2:0]  dp_pos = 3'd0;
    logic        char_ready = 1'b0;
    logic        char_valid;
    logic [3:0]  char_code;
    logic [2:0]  char_idx;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_word = 32'hEEEEEEEE;
    int          exp_idx = 0;
    bit          exp_done = 1'b0;
    int          done_count = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    num_formatter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .value      (value),
        .dp_pos     (dp_pos),
        .char_ready (char_ready),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_idx   (char_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected frame from plain decimal arithmetic; slot i lives in word[4*(7-i) +: 4].
    function automatic logic [31:0] model(input int v, input int dp_in);
        int          mag;
        int          dp;
        int          n;
        int          p;
        int          digs[5];
        logic [3:0]  f[8];
        logic [31:0] w;
        mag = (v < 0) ? -v : v;
        dp  = (dp_in > 4) ? 4 : dp_in;
        for (int i = 0; i < 5; i++) begin
            digs[i] = mag % 10;
            mag     = mag / 10;
        end
        n = dp + 1;
        for (int i = 0; i < 5; i++) begin
            if (digs[i] != 0 && i + 1 > n) n = i + 1;
        end
        for (int i = 0; i < 8; i++) f[i] = 4'hE;
        p = 7;
        for (int i = 0; i < n; i++) begin
            if (dp > 0 && i == dp) begin
                f[p] = 4'hC;
                p--;
            end
            f[p] = 4'(digs[i]);
            p--;
        end
        if (v < 0) f[p] = 4'hF;
        w = 32'd0;
        for (int i = 0; i < 8; i++) w[4*(7-i) +: 4] = f[i];
        return w;
    endfunction

    function automatic logic [3:0] slot_of(input logic [31:0] w, input int idx);
        return w[4*(7-(idx % 8)) +: 4];
    endfunction

    // Stream monitor: inputs change #1 after posedge, so negedge sees what the next edge samples.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_idx  = 0;
            exp_done = 1'b0;
        end else if (mon_en) begin
            check("done_pulse", {31'd0, done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (done) done_count++;
            if (char_valid) begin
                check("char_idx", {29'd0, char_idx}, 32'(exp_idx % 8));
                check("char_code", {28'd0, char_code}, {28'd0, slot_of(exp_word, exp_idx)});
                if (char_ready) begin
                    if (exp_idx == 7) exp_done = 1'b1;
                    exp_idx++;
                end
            end
        end
    end

    // mode 0: ready held high; mode 1: random ready; mode 2: ready high, start spammed while busy.
    task automatic run_frame(input string name, input int v, input int dp, input int mode);
        int cyc;
        int first_valid;
        int dc0;
        @(posedge clk);
        #1;
        exp_word   = model(v, dp);
        exp_idx    = 0;
        dc0        = done_count;
        value      = 16'(v);
        dp_pos     = 3'(dp);
        start      = 1'b1;
        char_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        cyc         = 0;
        first_valid = -1;
        while (1) begin
            if (mode == 2) start = 1'($urandom_range(0, 1));
            if (mode == 1) char_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
            if (char_valid && first_valid < 0) first_valid = cyc;
            if (done) break;
            if (cyc > 400) begin
                check({name, "_timeout"}, 32'(cyc), 32'd0);
                break;
            end
        end
        start      = 1'b0;
        char_ready = 1'b1;
        // Counted in edges from the edge where start was first driven.
        if (mode != 1) begin
            check({name, "_first_valid_edge"}, 32'(first_valid + 1), 32'd18);
            check({name, "_done_edge"}, 32'(cyc + 1), 32'd26);
        end
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({name, "_valid_at_done"}, {31'd0, char_valid}, 32'd0);
        check({name, "_slots_sent"}, 32'(exp_idx), 32'd8);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_done_count"}, 32'(done_count - dc0), 32'd1);
        check({name, "_idle_after"}, {30'd0, busy, char_valid}, 32'd0);
    endtask

    initial begin
        int dc0;
        bit found;

        check("model_1234_dp2", model(1234, 2), 32'hEEE12C34);
        check("model_m5_dp3", model(-5, 3), 32'hEEF0C005);
        check("model_0_dp0", model(0, 0), 32'hEEEEEEE0);
        check("model_m32768_dp0", model(-32768, 0), 32'hEEF32768);
        check("model_32767_dp7", model(32767, 7), 32'hEE3C2767);
        check("model_7_dp0", model(7, 0), 32'hEEEEEEE7);

        #12;
        check("rst_valid", {31'd0, char_valid}, 32'd0);
        check("rst_code", {28'd0, char_code}, 32'hE);
        check("rst_idx", {29'd0, char_idx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        #5 rst_n = 1'b1;
        mon_en = 1'b1;

        run_frame("v1234", 1234, 2, 0);
        run_frame("vm5", -5, 3, 0);
        run_frame("v0", 0, 0, 0);
        run_frame("vm32768", -32768, 0, 0);
        run_frame("v32767", 32767, 7, 0);
        run_frame("v1234_bp", 1234, 2, 1);
        run_frame("vm5_spam", -5, 3, 2);

        // Reset during SEND at slot 4.
        @(posedge clk);
        #1;
        exp_word   = model(999, 1);
        exp_idx    = 0;
        value      = 16'd999;
        dp_pos     = 3'd1;
        start      = 1'b1;
        char_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dc0   = done_count;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (char_valid && char_idx == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_mid_reached_slot4", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, char_valid}, 32'd0);
        check("rst_mid_code", {28'd0, char_code}, 32'hE);
        check("rst_mid_idx", {29'd0, char_idx}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        check("rst_mid_no_done", 32'(done_count - dc0), 32'd0);

        run_frame("v7_after_rst", 7, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
